// File: rtl/approx_mult_pkg.sv
// Shared constants and helpers for the tiled approximate multiplier.
package approx_mult_pkg;

  localparam int TILE_W   = 4;
  localparam int TILE_P_W = 8;

  // N1 approximate 4x4 cell: low columns are ORed instead of summed.
  function automatic logic [TILE_P_W-1:0] n1_mul4(logic [TILE_W-1:0] x, logic [TILE_W-1:0] y);
    logic [TILE_W-1:0][TILE_W-1:0] p;
    logic [TILE_P_W-1:0] r;
    logic c;
    for (int i = 0; i < TILE_W; i++)
      for (int j = 0; j < TILE_W; j++)
        p[i][j] = x[i] & y[j];
    c    = p[2][2] & (p[1][3] | p[3][1]);
    r[0] = p[0][0];
    r[1] = p[1][0] | p[0][1];
    r[2] = p[2][0] | p[1][1] | p[0][2];
    r[3] = p[3][0] | p[2][1] | p[1][2] | p[0][3];
    r[4] = p[3][1] | p[2][2] | p[1][3];
    r[5] = p[3][2] ^ p[2][3] ^ c;
    r[6] = (p[3][3] & ~p[2][2]) | (~p[3][3] & p[2][2] & (p[3][1] | p[1][3]));
    r[7] = p[2][2] & p[3][3];
    return r;
  endfunction

  function automatic bit tile_is_approx(int i, int j, int approx_cols);
    return (i + j) < approx_cols;
  endfunction

endpackage

// File: rtl/mul4_tile.sv
// One 4x4 tile: exact product or the N1 approximation.
module mul4_tile
  import approx_mult_pkg::*;
(
  input  logic [TILE_W-1:0]   x,
  input  logic [TILE_W-1:0]   y,
  input  logic                use_n1,
  output logic [TILE_P_W-1:0] p
);

  logic [TILE_P_W-1:0] p_exact;

  assign p_exact = {4'b0, x} * {4'b0, y};
  assign p       = use_n1 ? n1_mul4(x, y) : p_exact;

endmodule

// File: rtl/approx_rec_mult_pipe.sv
// Two-stage recursive multiplier: S1 registers tile products, S2 registers the weighted sum.
module approx_rec_mult_pipe
  import approx_mult_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int APPROX_COLS = 2,
  parameter int TAG_W       = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_approx,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_approx
);

  localparam int T  = WIDTH / TILE_W;
  localparam int NT = T * T;
  localparam int PW = 2 * WIDTH;
  localparam int AW = 2 * WIDTH + 2;

  if (WIDTH % TILE_W != 0 || WIDTH < TILE_W) begin : g_bad_width
    $error("approx_rec_mult_pipe: WIDTH must be a multiple of 4 and >= 4");
  end
  if (APPROX_COLS > 2 * T - 1) begin : g_bad_cols
    $error("approx_rec_mult_pipe: APPROX_COLS exceeds 2*T-1");
  end

  logic                          advance, accept;
  logic [1:0]                    vld_pipe;
  logic [NT-1:0][TILE_P_W-1:0]   tile_p, s1_p;
  logic [TAG_W-1:0]              s1_tag;
  logic                          s1_approx;
  logic [AW-1:0]                 sum;
  logic                          unused_sum_hi;

  assign advance   = ~out_valid | out_ready;
  assign in_ready  = advance;
  assign accept    = in_valid & advance;
  assign out_valid = vld_pipe[1];

  for (genvar i = 0; i < T; i++) begin : g_row
    for (genvar j = 0; j < T; j++) begin : g_col
      localparam bit TILE_APPROX = tile_is_approx(i, j, APPROX_COLS);
      mul4_tile u_tile (
        .x      (in_a[TILE_W*i +: TILE_W]),
        .y      (in_b[TILE_W*j +: TILE_W]),
        .use_n1 (in_approx & TILE_APPROX),
        .p      (tile_p[i*T+j])
      );
    end
  end

  // Tile (i,j) carries weight 2^(4*(i+j)); the two guard bits are dropped on output.
  always_comb begin
    sum = '0;
    for (int i = 0; i < T; i++)
      for (int j = 0; j < T; j++)
        sum = sum + (AW'(s1_p[i*T+j]) << (TILE_W * (i + j)));
  end
  assign unused_sum_hi = ^sum[AW-1:PW];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe   <= '0;
      s1_p       <= '0;
      s1_tag     <= '0;
      s1_approx  <= 1'b0;
      out_p      <= '0;
      out_tag    <= '0;
      out_approx <= 1'b0;
    end else if (advance) begin
      vld_pipe <= {vld_pipe[0], accept};
      if (accept) begin
        s1_p      <= tile_p;
        s1_tag    <= in_tag;
        s1_approx <= in_approx;
      end
      if (vld_pipe[0]) begin
        out_p      <= sum[PW-1:0];
        out_tag    <= s1_tag;
        out_approx <= s1_approx;
      end
    end
  end

endmodule

// File: tb/tb_approx_rec_mult_pipe.sv
// Bench: directed vector table, backpressure/reset sequences, randomized scoreboard run.
module tb_approx_rec_mult_pipe;

  localparam int W  = 8;
  localparam int TW = 4;
  localparam int AC = 2;
  localparam int T  = W / 4;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, in_approx, out_valid, out_ready, out_approx;
  logic [W-1:0]  in_a, in_b;
  logic [TW-1:0] in_tag, out_tag;
  logic [2*W-1:0] out_p;

  int n_chk = 0, n_fail = 0;
  bit mon_en = 0;

  typedef struct { logic [2*W-1:0] p; logic [TW-1:0] tag; logic ap; } exp_t;
  exp_t sbq[$];

  typedef struct { logic [W-1:0] a, b; logic ap; logic [TW-1:0] tag; logic [2*W-1:0] p; } vec_t;
  vec_t vt[7];

  always #5 clk = ~clk;

  approx_rec_mult_pipe #(.WIDTH(W), .APPROX_COLS(AC), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_approx(in_approx), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_tag(out_tag), .out_approx(out_approx)
  );

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // N1 viewed column-wise: columns 0..4 collapse to an OR, the top columns follow the cell rules.
  function automatic logic [7:0] n1_ref(logic [3:0] x, logic [3:0] y);
    int cnt[8];
    logic [7:0] r;
    bit p22, p33, p13, p31, p23, p32;
    for (int k = 0; k < 8; k++) cnt[k] = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (x[i] && y[j]) cnt[i+j]++;
    r = '0;
    for (int k = 0; k < 5; k++) r[k] = (cnt[k] > 0);
    p22 = x[2] & y[2]; p33 = x[3] & y[3]; p13 = x[1] & y[3];
    p31 = x[3] & y[1]; p23 = x[2] & y[3]; p32 = x[3] & y[2];
    r[5] = p32 ^ p23 ^ (p22 & (p13 | p31));
    r[6] = (p33 & ~p22) | (~p33 & p22 & (p31 | p13));
    r[7] = p22 & p33;
    return r;
  endfunction

  function automatic logic [2*W-1:0] ref_mult(logic [W-1:0] a, logic [W-1:0] b, logic ap);
    longint acc;
    longint t;
    int x, y;
    acc = 0;
    for (int i = 0; i < T; i++)
      for (int j = 0; j < T; j++) begin
        x = (int'(a) >> (4*i)) % 16;
        y = (int'(b) >> (4*j)) % 16;
        if (ap && (i + j) < AC) t = longint'(n1_ref(4'(x), 4'(y)));
        else t = longint'(x * y);
        acc = acc + t * (longint'(1) << (4*(i+j)));
      end
    return (2*W)'(acc % (longint'(1) << (2*W)));
  endfunction

  // Monitor: scoreboard, stall stability and in_ready backpressure, sampled on the falling edge.
  initial begin
    bit stall_prev;
    logic [2*W-1:0] h_p;
    logic [TW-1:0] h_tag;
    logic h_ap;
    exp_t e;
    stall_prev = 0; h_p = '0; h_tag = '0; h_ap = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sbq.delete();
        stall_prev = 0;
      end else if (mon_en) begin
        if (stall_prev)
          chk("stall_hold", {out_valid, out_approx, out_tag, out_p}, {1'b1, h_ap, h_tag, h_p});
        if (out_valid) chk("in_ready_bp", in_ready, out_ready);
        if (out_valid && out_ready) begin
          if (sbq.size() == 0) chk("sb_extra", 1, 0);
          else begin
            e = sbq.pop_front();
            chk("sb_p", out_p, e.p);
            chk("sb_tag", out_tag, e.tag);
            chk("sb_approx", out_approx, e.ap);
          end
        end
        if (in_valid && in_ready) begin
          e.p = ref_mult(in_a, in_b, in_approx); e.tag = in_tag; e.ap = in_approx;
          sbq.push_back(e);
        end
        stall_prev = out_valid && !out_ready;
        h_p = out_p; h_tag = out_tag; h_ap = out_approx;
      end
    end
  end

  task automatic send(logic [W-1:0] a, logic [W-1:0] b, logic ap, logic [TW-1:0] tag, inout int cyc);
    bit got;
    int n;
    in_a = a; in_b = b; in_approx = ap; in_tag = tag; in_valid = 1;
    n = 0;
    do begin
      @(negedge clk); got = in_ready;
      @(posedge clk); #1;
      cyc++;
      out_ready = !(cyc >= 3 && cyc < 6);
      n++;
    end while (!got && n < 50);
    if (!got) chk("send_timeout", 0, 1);
  endtask

  initial begin
    int cyc;
    vt[0] = '{8'd200, 8'd150, 1'b0, 4'd5, 16'd30000};
    vt[1] = '{8'h03,  8'h03,  1'b1, 4'd1, 16'd7};
    vt[2] = '{8'h03,  8'h03,  1'b0, 4'd2, 16'd9};
    vt[3] = '{8'hFF,  8'hFF,  1'b1, 4'd3, 16'd63903};
    vt[4] = '{8'hFF,  8'hFF,  1'b0, 4'd4, 16'd65025};
    vt[5] = '{8'h23,  8'h11,  1'b1, 4'd6, 16'd595};
    vt[6] = '{8'h00,  8'hFF,  1'b1, 4'd15, 16'd0};

    rst = 1; in_valid = 1; in_a = 8'hAB; in_b = 8'hCD; in_approx = 0; in_tag = 4'd9; out_ready = 1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_p", out_p, 0);
    end
    rst = 0; in_valid = 0;
    @(posedge clk); #1;
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_p", {out_approx, out_tag, out_p}, 0);
    chk("post_rst_ready", in_ready, 1);

    foreach (vt[k]) begin
      in_a = vt[k].a; in_b = vt[k].b; in_approx = vt[k].ap; in_tag = vt[k].tag; in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0;
      chk("vec_lat1_valid", out_valid, 0);
      @(posedge clk); #1;
      chk("vec_valid", out_valid, 1);
      chk("vec_p", out_p, vt[k].p);
      chk("vec_tag", out_tag, vt[k].tag);
      chk("vec_approx", out_approx, vt[k].ap);
      @(posedge clk); #1;
    end

    // Six back-to-back ops with a three-cycle downstream stall in the middle.
    mon_en = 1; cyc = 0;
    for (int k = 0; k < 6; k++)
      send(W'($urandom), W'($urandom), 1'($urandom), TW'(k), cyc);
    in_valid = 0; out_ready = 1;
    for (int n = 0; n < 20 && sbq.size() != 0; n++) @(posedge clk);
    #1 chk("bp_drained", sbq.size(), 0);

    // Randomized traffic with random backpressure.
    for (int k = 0; k < 400; k++) begin
      in_valid = ($urandom % 4) != 0;
      in_a = W'($urandom); in_b = W'($urandom);
      in_approx = 1'($urandom); in_tag = TW'($urandom);
      out_ready = ($urandom % 4) != 0;
      @(posedge clk); #1;
    end
    in_valid = 0; out_ready = 1;
    for (int n = 0; n < 20 && sbq.size() != 0; n++) @(posedge clk);
    #1 chk("rand_drained", sbq.size(), 0);

    // Reset in the middle of a stalled stream flushes everything in flight.
    in_valid = 1; out_ready = 0;
    for (int k = 0; k < 4; k++) begin
      in_a = W'($urandom); in_b = W'($urandom); in_tag = TW'(k);
      @(posedge clk); #1;
    end
    chk("pre_rst_stalled", out_valid, 1);
    rst = 1;
    @(posedge clk); #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_p", out_p, 0);
    rst = 0; in_valid = 0; out_ready = 1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("flush_no_out", out_valid, 0);
    end
    chk("flush_sb_empty", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
